// File: rtl/param_reg_file.sv
// ---------------------------------------------------------------------------
// param_reg_file
//   Parametrised decode-stage register file.
//   - Two combinational read ports with write-to-read bypass.
//   - One synchronous write port.
//   - Optional hardwired-zero register 0.
//   - Per-register pending scoreboard for hazard detection.
//   - Sequential clear engine that zeroes the whole array one entry per cycle.
//
// Ports
//   clk, rst_n             clock (rising edge) / asynchronous active-low reset
//   rd_addr1/2, rd_data1/2 read indices and combinational read data
//   wr_en, wr_addr, wr_data write strobe, index and data
//   pend_set, pend_addr    mark an index as awaiting writeback
//   pend1, pend2           pending status of rd_addr1 / rd_addr2 (combinational)
//   clr_req                start a full-array clear
//   clr_busy               clear sweep in progress
//   clr_done               one-cycle pulse when the sweep has finished
// ---------------------------------------------------------------------------
module param_reg_file #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              pend1,
    output logic              pend2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam bit                HAS_ZERO = (ZERO_R0 != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                clr_busy_q, clr_busy_d;
    logic                clr_done_q, clr_done_d;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;

    logic in_sweep;
    logic wr_ok;
    logic pend_ok;
    logic wr_hit1, wr_hit2;
    logic is_zero1, is_zero2;

    // While sweeping, the write and scoreboard ports are frozen and reads
    // see only the stored array.
    assign in_sweep = (state_q == ST_SWEEP);
    assign wr_ok    = wr_en && !in_sweep && !(HAS_ZERO && (wr_addr == '0));
    assign pend_ok  = pend_set && !in_sweep && !(HAS_ZERO && (pend_addr == '0));

    assign wr_hit1  = wr_en && !in_sweep && (wr_addr == rd_addr1);
    assign wr_hit2  = wr_en && !in_sweep && (wr_addr == rd_addr2);
    assign is_zero1 = HAS_ZERO && (rd_addr1 == '0);
    assign is_zero2 = HAS_ZERO && (rd_addr2 == '0);

    // ------------------------------------------------------------------
    // Read ports: hardwired zero beats bypass, bypass beats stored value.
    // A write about to land also masks the pending bit it will clear.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        if (wr_hit1) begin
            rd_data1 = wr_data;
        end
        if (is_zero1) begin
            rd_data1 = '0;
        end

        rd_data2 = regs_q[rd_addr2];
        if (wr_hit2) begin
            rd_data2 = wr_data;
        end
        if (is_zero2) begin
            rd_data2 = '0;
        end

        pend1 = pend_q[rd_addr1] && !wr_hit1 && !is_zero1;
        pend2 = pend_q[rd_addr2] && !wr_hit2 && !is_zero2;
    end

    // ------------------------------------------------------------------
    // Array and scoreboard next state. The set is applied after the
    // write-clear so a same-index set/write pair leaves the bit set.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        pend_d = pend_q;

        if (in_sweep) begin
            regs_d[cnt_q] = '0;
            pend_d[cnt_q] = 1'b0;
        end else begin
            if (wr_ok) begin
                regs_d[wr_addr] = wr_data;
                pend_d[wr_addr] = 1'b0;
            end
            if (pend_ok) begin
                pend_d[pend_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Clear engine. The counter holds at the last index rather than
    // wrapping; it is reloaded with 0 when the next sweep starts.
    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        clr_busy_d = (state_d == ST_SWEEP);
        clr_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_param_reg_file.sv
module tb_param_reg_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: default parameters ----------------
    logic        a_rst_n;
    logic [3:0]  a_rd_addr1, a_rd_addr2, a_wr_addr, a_pend_addr;
    logic [15:0] a_rd_data1, a_rd_data2, a_wr_data;
    logic        a_wr_en, a_pend_set, a_pend1, a_pend2;
    logic        a_clr_req, a_clr_busy, a_clr_done;

    param_reg_file dut_a (
        .clk      (clk),
        .rst_n    (a_rst_n),
        .rd_addr1 (a_rd_addr1),
        .rd_addr2 (a_rd_addr2),
        .rd_data1 (a_rd_data1),
        .rd_data2 (a_rd_data2),
        .wr_en    (a_wr_en),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .pend_set (a_pend_set),
        .pend_addr(a_pend_addr),
        .pend1    (a_pend1),
        .pend2    (a_pend2),
        .clr_req  (a_clr_req),
        .clr_busy (a_clr_busy),
        .clr_done (a_clr_done)
    );

    // ---------------- DUT B: 32 x 32, no hardwired zero ----------------
    logic        b_rst_n;
    logic [4:0]  b_rd_addr1, b_rd_addr2, b_wr_addr, b_pend_addr;
    logic [31:0] b_rd_data1, b_rd_data2, b_wr_data;
    logic        b_wr_en, b_pend_set, b_pend1, b_pend2;
    logic        b_clr_req, b_clr_busy, b_clr_done;

    param_reg_file #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0)) dut_b (
        .clk      (clk),
        .rst_n    (b_rst_n),
        .rd_addr1 (b_rd_addr1),
        .rd_addr2 (b_rd_addr2),
        .rd_data1 (b_rd_data1),
        .rd_data2 (b_rd_data2),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .pend_set (b_pend_set),
        .pend_addr(b_pend_addr),
        .pend1    (b_pend1),
        .pend2    (b_pend2),
        .clr_req  (b_clr_req),
        .clr_busy (b_clr_busy),
        .clr_done (b_clr_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0;
        a_pend_set = 0; a_pend_addr = 0;
        a_rd_addr1 = 0; a_rd_addr2 = 0; a_clr_req = 0;
    endtask

    task automatic b_idle();
        b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
        b_pend_set = 0; b_pend_addr = 0;
        b_rd_addr1 = 0; b_rd_addr2 = 0; b_clr_req = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        ps;
        logic [3:0]  pa;
        logic [3:0]  r1, r2;
        logic [15:0] e1, e2;
        logic        ep1, ep2;
    } vec_t;

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [15:0] wd,
                                logic ps, logic [3:0] pa, logic [3:0] r1, logic [3:0] r2,
                                logic [15:0] e1, logic [15:0] e2, logic ep1, logic ep2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ps = ps; v.pa = pa;
        v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2; v.ep1 = ep1; v.ep2 = ep2;
        return v;
    endfunction

    vec_t vecs[16];

    // ---------------- reference model (random phase) ----------------
    logic [15:0] m_reg [16];
    bit          m_pend[16];

    function automatic logic [15:0] m_read(logic [3:0] a, logic we, logic [3:0] wa, logic [15:0] wd);
        if (a == 0) return 16'h0;
        if (we && wa == a) return wd;
        return m_reg[a];
    endfunction

    function automatic logic m_pending(logic [3:0] a, logic we, logic [3:0] wa);
        if (a == 0) return 1'b0;
        return m_pend[a] && !(we && wa == a);
    endfunction

    // ---------------- clear measurement ----------------
    task automatic run_clear(input bit sel, input int nregs, input string tag);
        int  busy_cnt, first_busy, last_busy, done_cyc, done_cnt, busy_in_done;
        logic bs, dn;
        busy_cnt = 0; first_busy = -1; last_busy = -1;
        done_cyc = -1; done_cnt = 0; busy_in_done = 0;
        if (sel) b_clr_req = 1; else a_clr_req = 1;
        tick();
        b_clr_req = 0; a_clr_req = 0;
        for (int c = 1; c <= nregs + 8; c++) begin
            bs = sel ? b_clr_busy : a_clr_busy;
            dn = sel ? b_clr_done : a_clr_done;
            if (bs) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (dn) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (bs) busy_in_done++;
            end
            if (!sel && c == 3) begin
                // R1 is already swept, R4 is not: writes/sets must be ignored
                // and reads must show stored contents with no bypass.
                a_wr_en = 1; a_wr_addr = 1; a_wr_data = 16'hBEEF;
                a_pend_set = 1; a_pend_addr = 2;
                a_rd_addr1 = 1; a_rd_addr2 = 4;
                #1;
                chk("sweep_rd_no_bypass", a_rd_data1, 32'h0);
                chk("sweep_rd_stored", a_rd_data2, 32'h5555);
                chk("sweep_pend_masked", a_pend1, 1'b0);
            end
            tick();
            if (!sel) a_idle();
        end
        chk({tag, "_first_busy"}, first_busy, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, nregs);
        chk({tag, "_last_busy"}, last_busy, nregs);
        chk({tag, "_done_cycle"}, done_cyc, nregs + 1);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_in_done"}, busy_in_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] e1, e2;
        logic        ep1, ep2;
        int          seen;

        a_rst_n = 1; b_rst_n = 1;
        a_idle(); b_idle();
        a_rd_addr1 = 3; a_rd_addr2 = 9;
        #2;
        a_rst_n = 0; b_rst_n = 0;
        #1;
        chk("rst_rd1", a_rd_data1, 0);
        chk("rst_rd2", a_rd_data2, 0);
        chk("rst_pend", {a_pend1, a_pend2}, 0);
        chk("rst_busy", a_clr_busy, 0);
        chk("rst_done", a_clr_done, 0);
        chk("rst_b_rd1", b_rd_data1, 0);
        tick(); tick();
        a_rst_n = 1; b_rst_n = 1;
        a_idle();
        tick();

        // ---------------- directed table ----------------
        vecs[0]  = mk(1, 3, 16'hA5A5, 0, 0, 3, 3, 16'hA5A5, 16'hA5A5, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 3, 3, 16'hA5A5, 16'hA5A5, 0, 0);
        vecs[2]  = mk(1, 0, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[3]  = mk(0, 0, 16'h0000, 0, 0, 0, 3, 16'h0000, 16'hA5A5, 0, 0);
        vecs[4]  = mk(1, 6, 16'h0606, 0, 0, 6, 6, 16'h0606, 16'h0606, 0, 0);
        vecs[5]  = mk(1, 5, 16'h1234, 0, 0, 5, 6, 16'h1234, 16'h0606, 0, 0);
        vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 5, 6, 16'h1234, 16'h0606, 0, 0);
        vecs[7]  = mk(0, 0, 16'h0000, 1, 7, 7, 7, 16'h0000, 16'h0000, 0, 0);
        vecs[8]  = mk(1, 7, 16'h0777, 0, 0, 7, 5, 16'h0777, 16'h1234, 0, 0);
        vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 7, 7, 16'h0777, 16'h0777, 0, 0);
        vecs[10] = mk(1, 7, 16'h7000, 1, 7, 7, 7, 16'h7000, 16'h7000, 0, 0);
        vecs[11] = mk(0, 0, 16'h0000, 0, 0, 7, 0, 16'h7000, 16'h0000, 1, 0);
        vecs[12] = mk(0, 0, 16'h0000, 1, 0, 0, 7, 16'h0000, 16'h7000, 0, 1);
        vecs[13] = mk(0, 0, 16'h0000, 0, 0, 0, 7, 16'h0000, 16'h7000, 0, 1);
        vecs[14] = mk(1, 9, 16'h9999, 1, 2, 9, 2, 16'h9999, 16'h0000, 0, 0);
        vecs[15] = mk(0, 0, 16'h0000, 0, 0, 9, 2, 16'h9999, 16'h0000, 0, 1);

        for (int i = 0; i < 16; i++) begin
            a_wr_en = vecs[i].we; a_wr_addr = vecs[i].wa; a_wr_data = vecs[i].wd;
            a_pend_set = vecs[i].ps; a_pend_addr = vecs[i].pa;
            a_rd_addr1 = vecs[i].r1; a_rd_addr2 = vecs[i].r2;
            #1;
            chk($sformatf("vec%0d_rd1", i), a_rd_data1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), a_rd_data2, vecs[i].e2);
            chk($sformatf("vec%0d_pend1", i), a_pend1, vecs[i].ep1);
            chk($sformatf("vec%0d_pend2", i), a_pend2, vecs[i].ep2);
            tick();
        end
        a_idle();

        // ---------------- randomized against model ----------------
        a_rst_n = 0;
        tick();
        a_rst_n = 1;
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = 0; m_pend[i] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            a_wr_en    = ($urandom_range(0, 1) == 1);
            a_wr_addr  = 4'($urandom_range(0, 15));
            a_wr_data  = 16'($urandom);
            a_pend_set = ($urandom_range(0, 2) == 0);
            a_pend_addr = 4'($urandom_range(0, 15));
            a_rd_addr1 = 4'($urandom_range(0, 15));
            a_rd_addr2 = ($urandom_range(0, 3) == 0) ? a_wr_addr : 4'($urandom_range(0, 15));
            #1;
            e1  = m_read(a_rd_addr1, a_wr_en, a_wr_addr, a_wr_data);
            e2  = m_read(a_rd_addr2, a_wr_en, a_wr_addr, a_wr_data);
            ep1 = m_pending(a_rd_addr1, a_wr_en, a_wr_addr);
            ep2 = m_pending(a_rd_addr2, a_wr_en, a_wr_addr);
            chk($sformatf("rand%0d_rd1", n), a_rd_data1, e1);
            chk($sformatf("rand%0d_rd2", n), a_rd_data2, e2);
            chk($sformatf("rand%0d_pend1", n), a_pend1, ep1);
            chk($sformatf("rand%0d_pend2", n), a_pend2, ep2);
            tick();
            if (a_wr_en && a_wr_addr != 0) begin
                m_reg[a_wr_addr]  = a_wr_data;
                m_pend[a_wr_addr] = 0;
            end
            if (a_pend_set && a_pend_addr != 0) m_pend[a_pend_addr] = 1;
        end
        a_idle();

        // ---------------- full clear, default params ----------------
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 1; a_wr_addr = 4'(i); a_wr_data = 16'((i + 1) * 16'h1111);
            if (i == 15) begin
                a_pend_set = 1; a_pend_addr = 9;
            end
            tick();
        end
        a_idle();
        a_rd_addr1 = 9; a_rd_addr2 = 15;
        #1;
        chk("fill_pend9", a_pend1, 1'b1);
        chk("fill_r15", a_rd_data2, 32'h1110);
        tick();
        a_idle();
        run_clear(1'b0, 16, "clrA");
        for (int i = 0; i < 16; i++) begin
            a_rd_addr1 = 4'(i); a_rd_addr2 = 4'(15 - i);
            #1;
            chk($sformatf("post_clr_rd_r%0d", i), a_rd_data1, 0);
            chk($sformatf("post_clr_pend_r%0d", i), {a_pend1, a_pend2}, 0);
            tick();
        end
        a_idle();

        // ---------------- reset during sweep ----------------
        a_wr_en = 1; a_wr_addr = 12; a_wr_data = 16'hCCCC;
        tick();
        a_idle();
        a_clr_req = 1;
        tick();
        a_clr_req = 0;
        for (int c = 1; c < 5; c++) tick();
        chk("midrst_busy_before", a_clr_busy, 1);
        #1;
        a_rst_n = 0;
        #1;
        chk("midrst_busy", a_clr_busy, 0);
        chk("midrst_done", a_clr_done, 0);
        a_rd_addr1 = 12;
        #1;
        chk("midrst_r12_zero", a_rd_data1, 0);
        tick();
        a_rst_n = 1;
        tick();
        chk("midrst_idle_busy", a_clr_busy, 0);
        chk("midrst_no_done", a_clr_done, 0);
        a_clr_req = 1;
        tick();
        a_clr_req = 0;
        chk("midrst_restart_busy", a_clr_busy, 1);
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            if (a_clr_done) seen = 1;
            else tick();
        end
        chk("midrst_restart_done", seen, 1);
        tick();
        a_idle();

        // ---------------- DUT B: 32-bit, 32 regs, R0 writable ----------------
        b_wr_en = 1; b_wr_addr = 31; b_wr_data = 32'hDEADBEEF;
        tick();
        b_wr_addr = 0; b_wr_data = 32'h1;
        b_rd_addr1 = 0;
        #1;
        chk("b_r0_bypass", b_rd_data1, 32'h1);
        tick();
        b_idle();
        b_rd_addr1 = 31; b_rd_addr2 = 0;
        #1;
        chk("b_r31", b_rd_data1, 32'hDEADBEEF);
        chk("b_r0", b_rd_data2, 32'h1);
        b_pend_set = 1; b_pend_addr = 0;
        tick();
        b_pend_set = 0;
        #1;
        chk("b_r0_pending", b_pend2, 1'b1);
        tick();
        b_idle();
        run_clear(1'b1, 32, "clrB");
        b_rd_addr1 = 31; b_rd_addr2 = 0;
        #1;
        chk("b_post_clr_r31", b_rd_data1, 0);
        chk("b_post_clr_r0", b_rd_data2, 0);
        chk("b_post_clr_pend", b_pend2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
